cgra_col_sequencer: RTL and testbench
=====================================

// Module: cgra_col_sequencer
// PURPOSE
//  Per-column program sequencer. Upstream of the CGRA array; one instance per column.
//  Launches a kernel at a given config-register address and steps the column PC.
//  Drives config read and PC enable, and reacts to the column's stall, branch and
//  exec-end signals. Reports done, and counts active and stall cycles for the host.
// PARAMETERS
//  N_CREG   default RCS_NUM_CREG (32)  : number of config words per RC
//  PC_W     default $clog2(N_CREG)     : PC width (= RCS_NUM_CREG_LOG2)
//  CNT_W    default 32                 : width of the performance counters
// PORTS
//  clk_i            in   1      clock; single clock domain
//  rst_i            in   1      synchronous reset, active-high
//  start_i          in   1      launch request; sampled only in IDLE
//  start_pc_i       in   PC_W   first config address of the kernel
//  abort_i          in   1      kill the running kernel
//  rcs_stall_i      in   1      column stall (already merged over columns via acc map)
//  rcs_br_req_i     in   1      branch request from the column
//  rcs_br_add_i     in   PC_W   branch target
//  exec_end_i       in   1      kernel end (already masked by branch request)
//  rcs_col_pc_o     out  PC_W   PC broadcast to the column RCs
//  rcs_conf_re_o    out  1      config-word read strobe
//  rcs_pc_e_o       out  1      PC enable: commits the RC results of the current instruction
//  rst_col_o        out  1      column reset to the RCs and the grant/rvalid masks
//  clk_en_o         out  1      column clock-gate enable
//  busy_o           out  1      kernel in flight
//  done_o           out  1      one-cycle pulse at normal completion
//  active_cnt_o     out  CNT_W  cycles spent in FETCH and EXEC
//  stall_cnt_o      out  CNT_W  EXEC cycles with rcs_stall_i=1
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except rst_col_o=1 while rst_i=1.
//   - State IDLE, pc=0, counters 0.
//  States: IDLE, INIT, FETCH, EXEC, DONE
//  IDLE
//   - start_i=1 -> INIT. pc<=start_pc_i. Both counters cleared.
//  INIT (1 cycle)
//   - rst_col_o=1, clk_en_o=1 -> FETCH.
//  FETCH (1 cycle)
//   - rcs_conf_re_o=1 with rcs_col_pc_o=pc -> EXEC.
//  EXEC
//   - rcs_pc_e_o = ~rcs_stall_i (combinational).
//   - Stalled: hold state and pc. stall_cnt increments.
//   - Not stalled (pc_e=1), in priority order:
//     - rcs_br_req_i=1 -> pc<=rcs_br_add_i -> FETCH.
//     - else exec_end_i=1 -> DONE.
//     - else pc<=pc+1 -> FETCH. Wraps modulo 2^PC_W; N_CREG-1 wraps to 0.
//   - exec_end_i or rcs_br_req_i while stalled: ignored. Re-evaluated when pc_e=1.
//  DONE (1 cycle)
//   - done_o=1 -> IDLE.
//  Per-instruction latency: 2 cycles minimum (FETCH+EXEC), plus stall cycles.
//  clk_en_o and busy_o: 1 in INIT, FETCH and EXEC; 0 in IDLE and DONE.
//  Counters: active_cnt increments in FETCH and EXEC. Both counters saturate at
//   all-ones and hold their value after the kernel ends until the next start.
//  abort_i: any non-IDLE state -> IDLE next cycle.
//   - rst_col_o=1 for that one cycle.
//   - No done_o.
//   - Counters frozen.
//  Simultaneous events
//   - abort_i beats start_i and beats all EXEC transitions.
//   - start_i outside IDLE is ignored (not queued).
//   - rst_i beats everything. rst_i mid-kernel -> IDLE, no done_o.
// STRUCTURE
//  cgra_pkg
//   - Existing: RCS_NUM_CREG, RCS_NUM_CREG_LOG2.
//   - Add: typedef enum logic [2:0] {SEQ_IDLE,SEQ_INIT,SEQ_FETCH,SEQ_EXEC,SEQ_DONE} seq_state_e.
//  Sub-module cgra_sat_cnt (CNT_W; ports clr, inc, cnt). Instantiated twice, for the
//   active and stall counters.
//  cgra_top instantiates N_COL sequencers and drives the cgra column vectors from them.
// TESTING
//  T1: start_pc=3, no stall, exec_end at pc=5 -> conf_re at pc 3,4,5; 3 pc_e
//      pulses; done 1 cycle after the last pc_e; active_cnt=6.
//  T2: stall held 4 cycles at pc=3 -> pc_e=0 for 4 cycles, pc stays 3;
//      stall_cnt=4; exec_end asserted during the stall is ignored.
//  T3: br_req at pc=7 with br_add=2, loop twice -> pc sequence 7,2,...,7,2;
//      exec_end in the same cycle as br_req does not finish the kernel.
//  T4: start_pc=31, N_CREG=32 -> next pc=0.
//      abort in EXEC -> IDLE next cycle, rst_col_o pulse, no done.
//  T5: start_i while busy -> ignored.
//      start+abort in the same IDLE cycle -> stays IDLE.
//      rst_i in FETCH -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared CGRA constants and types used by the column sequencer and its helpers.
package cgra_pkg;

   localparam int RCS_NUM_CREG      = 32;
   localparam int RCS_NUM_CREG_LOG2 = $clog2(RCS_NUM_CREG);

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_INIT,
      SEQ_FETCH,
      SEQ_EXEC,
      SEQ_DONE
   } seq_state_e;

endpackage

// File: rtl/cgra_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module cgra_sat_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cgra_col_sequencer.sv
// Per-column program sequencer: launches a kernel, steps the column PC through
// fetch/execute, follows branches and stalls, and keeps host performance counters.
module cgra_col_sequencer
   import cgra_pkg::*;
#(
   parameter int N_CREG = RCS_NUM_CREG,
   parameter int PC_W   = $clog2(N_CREG),
   parameter int CNT_W  = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [PC_W-1:0]  start_pc_i,
   input  logic             abort_i,
   input  logic             rcs_stall_i,
   input  logic             rcs_br_req_i,
   input  logic [PC_W-1:0]  rcs_br_add_i,
   input  logic             exec_end_i,
   output logic [PC_W-1:0]  rcs_col_pc_o,
   output logic             rcs_conf_re_o,
   output logic             rcs_pc_e_o,
   output logic             rst_col_o,
   output logic             clk_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] active_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   seq_state_e      state, state_next;
   logic [PC_W-1:0] pc, pc_next;

   logic conf_re, pc_e, rst_col, clk_en, busy, done;
   logic cnt_clr, active_inc, stall_inc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= SEQ_IDLE;
         pc    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      conf_re    = 1'b0;
      pc_e       = 1'b0;
      rst_col    = 1'b0;
      clk_en     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cnt_clr    = 1'b0;
      active_inc = 1'b0;
      stall_inc  = 1'b0;

      case (state)
         SEQ_IDLE: begin
            if (start_i && !abort_i) begin
               state_next = SEQ_INIT;
               pc_next    = start_pc_i;
               cnt_clr    = 1'b1;
            end
         end
         SEQ_INIT: begin
            rst_col    = 1'b1;
            clk_en     = 1'b1;
            busy       = 1'b1;
            state_next = SEQ_FETCH;
         end
         SEQ_FETCH: begin
            conf_re    = 1'b1;
            clk_en     = 1'b1;
            busy       = 1'b1;
            active_inc = 1'b1;
            state_next = SEQ_EXEC;
         end
         SEQ_EXEC: begin
            clk_en     = 1'b1;
            busy       = 1'b1;
            active_inc = 1'b1;
            // Branch and end requests only count on the cycle the results commit.
            if (rcs_stall_i) begin
               stall_inc = 1'b1;
            end else begin
               pc_e = 1'b1;
               if (rcs_br_req_i) begin
                  pc_next    = rcs_br_add_i;
                  state_next = SEQ_FETCH;
               end else if (exec_end_i) begin
                  state_next = SEQ_DONE;
               end else begin
                  pc_next    = pc + 1'b1;
                  state_next = SEQ_FETCH;
               end
            end
         end
         SEQ_DONE: begin
            done       = 1'b1;
            state_next = SEQ_IDLE;
         end
         default: begin
            state_next = SEQ_IDLE;
         end
      endcase

      // Abort kills the kernel outright: nothing commits, no done, counters freeze.
      if (abort_i && (state != SEQ_IDLE)) begin
         state_next = SEQ_IDLE;
         pc_next    = pc;
         rst_col    = 1'b1;
         pc_e       = 1'b0;
         done       = 1'b0;
         active_inc = 1'b0;
         stall_inc  = 1'b0;
      end
   end

   // While reset is held the column sees only its reset, whatever the current state.
   assign rcs_col_pc_o  = pc;
   assign rcs_conf_re_o = conf_re & ~rst_i;
   assign rcs_pc_e_o    = pc_e & ~rst_i;
   assign rst_col_o     = rst_col | rst_i;
   assign clk_en_o      = clk_en & ~rst_i;
   assign busy_o        = busy & ~rst_i;
   assign done_o        = done & ~rst_i;

   cgra_sat_cnt #(.CNT_W(CNT_W)) u_active_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (cnt_clr),
      .inc (active_inc),
      .cnt (active_cnt_o)
   );

   cgra_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (cnt_clr),
      .inc (stall_inc),
      .cnt (stall_cnt_o)
   );

endmodule

// File: tb/tb_cgra_col_sequencer.sv
// Randomized self-checking bench for cgra_col_sequencer against a program-level model.
module tb_cgra_col_sequencer;
   import cgra_pkg::*;

   localparam int PC_W  = RCS_NUM_CREG_LOG2;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [PC_W-1:0]  start_pc_i;
   logic             abort_i;
   logic             rcs_stall_i;
   logic             rcs_br_req_i;
   logic [PC_W-1:0]  rcs_br_add_i;
   logic             exec_end_i;
   logic [PC_W-1:0]  rcs_col_pc_o;
   logic             rcs_conf_re_o;
   logic             rcs_pc_e_o;
   logic             rst_col_o;
   logic             clk_en_o;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] active_cnt_o;
   logic [CNT_W-1:0] stall_cnt_o;

   logic [5:0] flags;
   assign flags = {rst_col_o, clk_en_o, busy_o, rcs_conf_re_o, rcs_pc_e_o, done_o};

   localparam logic [5:0] F_IDLE  = 6'b000000;
   localparam logic [5:0] F_INIT  = 6'b111000;
   localparam logic [5:0] F_FETCH = 6'b011100;
   localparam logic [5:0] F_STALL = 6'b011000;
   localparam logic [5:0] F_EXEC  = 6'b011010;
   localparam logic [5:0] F_ABORT = 6'b111000;
   localparam logic [5:0] F_DONE  = 6'b000001;
   localparam logic [5:0] F_RESET = 6'b100000;

   int vectors = 0;
   int miscompares = 0;

   // One program instruction: stall cycles before commit, then 0=next, 1=branch, 2=end.
   typedef struct {
      int              stalls;
      int              act;
      logic [PC_W-1:0] tgt;
   } instr_t;

   instr_t prog[$];
   int     exp_active;
   int     exp_stall;

   always #5 clk_i = ~clk_i;

   cgra_col_sequencer #(.CNT_W(CNT_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .start_pc_i    (start_pc_i),
      .abort_i       (abort_i),
      .rcs_stall_i   (rcs_stall_i),
      .rcs_br_req_i  (rcs_br_req_i),
      .rcs_br_add_i  (rcs_br_add_i),
      .exec_end_i    (exec_end_i),
      .rcs_col_pc_o  (rcs_col_pc_o),
      .rcs_conf_re_o (rcs_conf_re_o),
      .rcs_pc_e_o    (rcs_pc_e_o),
      .rst_col_o     (rst_col_o),
      .clk_en_o      (clk_en_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .active_cnt_o  (active_cnt_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      rst_i        = 1'b0;
      start_i      = 1'b0;
      start_pc_i   = '0;
      abort_i      = 1'b0;
      rcs_stall_i  = 1'b0;
      rcs_br_req_i = 1'b0;
      rcs_br_add_i = '0;
      exec_end_i   = 1'b0;
   endtask

   // Runs prog from spc; abort_idx >= 0 aborts on the commit cycle of that instruction.
   task automatic applyStimulus(input logic [PC_W-1:0] spc, input int abort_idx, input string tag);
      logic [PC_W-1:0] exp_pc;
      exp_pc = spc;
      start_i = 1'b1;
      start_pc_i = spc;
      rcs_stall_i = 1'($urandom_range(1));
      @(negedge clk_i);
      vectors++;
      if (flags !== F_IDLE) begin
         miscompares++;
         $display("[TB] FAIL %s idle_flags: got %b want %b", tag, flags, F_IDLE);
      end
      next_cycle();
      start_i = 1'($urandom_range(1));
      start_pc_i = PC_W'($urandom);
      rcs_stall_i = 1'b0;
      exp_active = 0;
      exp_stall = 0;
      @(negedge clk_i);
      vectors++;
      if (flags !== F_INIT) begin
         miscompares++;
         $display("[TB] FAIL %s init_flags: got %b want %b", tag, flags, F_INIT);
      end
      next_cycle();
      foreach (prog[i]) begin
         start_i = 1'($urandom_range(1));
         rcs_br_req_i = 1'($urandom_range(1));
         exec_end_i = 1'($urandom_range(1));
         rcs_br_add_i = PC_W'($urandom);
         @(negedge clk_i);
         vectors++;
         if (flags !== F_FETCH || rcs_col_pc_o !== exp_pc) begin
            miscompares++;
            $display("[TB] FAIL %s fetch[%0d]: got flags %b pc %0d want %b pc %0d",
                     tag, i, flags, rcs_col_pc_o, F_FETCH, exp_pc);
         end
         exp_active++;
         next_cycle();
         for (int s = 0; s < prog[i].stalls; s++) begin
            rcs_stall_i = 1'b1;
            exec_end_i = 1'b1;
            rcs_br_req_i = 1'($urandom_range(1));
            @(negedge clk_i);
            vectors++;
            if (flags !== F_STALL || rcs_col_pc_o !== exp_pc) begin
               miscompares++;
               $display("[TB] FAIL %s stall[%0d.%0d]: got flags %b pc %0d want %b pc %0d",
                        tag, i, s, flags, rcs_col_pc_o, F_STALL, exp_pc);
            end
            exp_active++;
            exp_stall++;
            next_cycle();
         end
         rcs_stall_i = 1'b0;
         rcs_br_req_i = (prog[i].act == 1);
         exec_end_i = (prog[i].act == 2) || (prog[i].act == 1 && $urandom_range(1) == 1);
         rcs_br_add_i = (prog[i].act == 1) ? prog[i].tgt : PC_W'($urandom);
         abort_i = (i == abort_idx);
         @(negedge clk_i);
         vectors++;
         if (flags !== (abort_i ? F_ABORT : F_EXEC) || rcs_col_pc_o !== exp_pc) begin
            miscompares++;
            $display("[TB] FAIL %s exec[%0d]: got flags %b pc %0d want %b pc %0d",
                     tag, i, flags, rcs_col_pc_o, abort_i ? F_ABORT : F_EXEC, exp_pc);
         end
         if (abort_i) begin
            next_cycle();
            idle_inputs();
            @(negedge clk_i);
            vectors++;
            if (flags !== F_IDLE || active_cnt_o !== CNT_W'(sat(exp_active))
                || stall_cnt_o !== CNT_W'(sat(exp_stall))) begin
               miscompares++;
               $display("[TB] FAIL %s after_abort: got flags %b act %0d stl %0d want %b act %0d stl %0d",
                        tag, flags, active_cnt_o, stall_cnt_o, F_IDLE, sat(exp_active), sat(exp_stall));
            end
            next_cycle();
            return;
         end
         exp_active++;
         exp_pc = (prog[i].act == 1) ? prog[i].tgt : exp_pc + 1'b1;
         next_cycle();
      end
      idle_inputs();
      @(negedge clk_i);
      vectors++;
      if (flags !== F_DONE) begin
         miscompares++;
         $display("[TB] FAIL %s done_flags: got %b want %b", tag, flags, F_DONE);
      end
      next_cycle();
      @(negedge clk_i);
      vectors++;
      if (flags !== F_IDLE || active_cnt_o !== CNT_W'(sat(exp_active))
          || stall_cnt_o !== CNT_W'(sat(exp_stall))) begin
         miscompares++;
         $display("[TB] FAIL %s end_counters: got flags %b act %0d stl %0d want %b act %0d stl %0d",
                  tag, flags, active_cnt_o, stall_cnt_o, F_IDLE, sat(exp_active), sat(exp_stall));
      end
      next_cycle();
   endtask

   task automatic push(input int stalls, input int act, input int tgt);
      instr_t ins;
      ins.stalls = stalls;
      ins.act = act;
      ins.tgt = PC_W'(tgt);
      prog.push_back(ins);
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1'b1;
      next_cycle();
      @(negedge clk_i);
      vectors++;
      if (flags !== F_RESET) begin
         miscompares++;
         $display("[TB] FAIL reset_hold: got %b want %b", flags, F_RESET);
      end
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (flags !== F_IDLE || rcs_col_pc_o !== '0 || active_cnt_o !== '0 || stall_cnt_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got flags %b pc %0d act %0d stl %0d want all 0",
                  flags, rcs_col_pc_o, active_cnt_o, stall_cnt_o);
      end
      next_cycle();
   endtask

   task automatic test_basic();
      prog.delete();
      push(0, 0, 0); push(0, 0, 0); push(0, 2, 0);
      applyStimulus(5'd3, -1, "basic");
   endtask

   task automatic test_stall();
      prog.delete();
      push(4, 2, 0);
      applyStimulus(5'd3, -1, "stall");
   endtask

   task automatic test_branch_loop();
      prog.delete();
      for (int l = 0; l < 2; l++) begin
         push(0, 1, 2);
         for (int p = 2; p < 7; p++) push(l, 0, 0);
      end
      push(0, 1, 2);
      push(1, 2, 0);
      applyStimulus(5'd7, -1, "branch");
   endtask

   task automatic test_wrap_abort();
      prog.delete();
      push(0, 0, 0); push(1, 2, 0);
      applyStimulus(5'd31, -1, "wrap");
      prog.delete();
      push(0, 0, 0); push(2, 0, 0); push(0, 2, 0);
      applyStimulus(5'd10, 1, "abort");
   endtask

   task automatic test_start_ignored();
      int prev_act, prev_stl;
      prev_act = int'(active_cnt_o);
      prev_stl = int'(stall_cnt_o);
      start_i = 1'b1;
      abort_i = 1'b1;
      start_pc_i = 5'd9;
      @(negedge clk_i);
      next_cycle();
      idle_inputs();
      @(negedge clk_i);
      vectors++;
      if (flags !== F_IDLE || int'(active_cnt_o) != prev_act || int'(stall_cnt_o) != prev_stl) begin
         miscompares++;
         $display("[TB] FAIL start_abort_idle: got flags %b act %0d stl %0d want %b act %0d stl %0d",
                  flags, active_cnt_o, stall_cnt_o, F_IDLE, prev_act, prev_stl);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      start_i = 1'b1;
      start_pc_i = 5'd12;
      next_cycle();
      start_i = 1'b0;
      next_cycle();
      rst_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (flags !== F_RESET) begin
         miscompares++;
         $display("[TB] FAIL reset_in_fetch: got %b want %b", flags, F_RESET);
      end
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (flags !== F_IDLE || rcs_col_pc_o !== '0 || active_cnt_o !== '0 || stall_cnt_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL after_mid_reset: got flags %b pc %0d act %0d stl %0d want all 0",
                  flags, rcs_col_pc_o, active_cnt_o, stall_cnt_o);
      end
      next_cycle();
   endtask

   task automatic test_random();
      int len, abort_idx;
      for (int k = 0; k < 12; k++) begin
         prog.delete();
         len = $urandom_range(8, 1);
         for (int j = 0; j < len; j++) begin
            push($urandom_range(3), (j == len - 1) ? 2 : $urandom_range(1), $urandom_range(31));
         end
         abort_idx = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
         applyStimulus(PC_W'($urandom), abort_idx, "random");
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_stall();
      test_branch_loop();
      test_wrap_abort();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
